pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//  Responder end of the cache pmem_read/pmem_write/pmem_resp line interface.
//  Accepts one 256-bit cache-line read or write from a cache controller.
//  Services it as a 4-beat x 64-bit burst on the main-memory side.
//  Returns a single-cycle pmem_resp with the assembled line held on pmem_rdata.
//  Sits between the cache arbiter output and the burst main memory.
// PARAMETERS
//  BEAT_W  64   width of one memory-side beat
//  BEATS   4    beats per line; LINE_W = BEAT_W*BEATS = 256
//  OFF_W   5    line offset bits, forced to 0 on burst_address
// PORTS
//  clk            in   1    clock, all state updates on posedge
//  rst            in   1    synchronous, active-high reset
//  pmem_read      in   1    line read request, held until pmem_resp
//  pmem_write     in   1    line write request, held until pmem_resp
//  pmem_address   in   32   line address from cache
//  pmem_wdata     in   256  write line, sampled in IDLE at request accept
//  pmem_rdata     out  256  read line buffer, registered
//  pmem_resp      out  1    request complete, 1-cycle pulse
//  burst_read     out  1    memory-side read burst active
//  burst_write    out  1    memory-side write burst active
//  burst_address  out  32   {pmem_address[31:5], 5'b0}, latched
//  burst_wdata    out  64   current write beat
//  burst_rdata    in   64   current read beat
//  burst_resp     in   1    beat accepted/valid this cycle
// BEHAVIOUR
//  Reset:
//   - all outputs 0; state=IDLE; beat_cnt=0; line buffer=0.
//   - Applies from any state, including mid-burst; a burst in flight is abandoned.
//  States: IDLE, RD_BURST, WR_BURST, RESP.
//  IDLE:
//   - pmem_read=1: latch addr with offset zeroed, beat_cnt=0, next RD_BURST.
//   - else pmem_write=1: latch addr, latch pmem_wdata into buffer, beat_cnt=0,
//     next WR_BURST.
//   - Both asserted is illegal; read wins, write is not serviced.
//   - Neither asserted: stay IDLE.
//  RD_BURST:
//   - burst_read=1 continuously; burst_address is stable.
//   - burst_resp=1: buffer[beat_cnt*64 +: 64] <= burst_rdata; beat_cnt++.
//   - burst_resp=0: hold; gaps between beats are legal.
//   - Beat 0 maps to bits [63:0].
//   - Beat BEATS-1 accepted: next RESP.
//  WR_BURST:
//   - burst_write=1; burst_wdata = buffer[beat_cnt*64 +: 64].
//   - beat_cnt advances only on burst_resp.
//   - Last beat accepted: next RESP.
//  RESP:
//   - pmem_resp=1 for exactly one cycle; burst_read and burst_write = 0.
//   - Next IDLE unconditionally.
//   - The requester drops its request in the cycle after pmem_resp.
//   - A request still high in IDLE is treated as a new request.
//  pmem_rdata:
//   - Driven from the line buffer.
//   - Holds the last read line until the next read burst overwrites it.
//   - A write also loads the buffer, so pmem_rdata is don't-care after a write.
//  Latency:
//   - Request seen in cycle 0 (IDLE).
//   - Back-to-back burst_resp in cycles 1..4.
//   - pmem_resp in cycle 5 (min 5 cycles); each stall cycle adds 1.
//  Invariants:
//   - burst_read and burst_write never both 1.
//   - beat_cnt wraps to 0 only via IDLE accept.
//   - burst_resp in IDLE/RESP is ignored.
// TESTING
//  1 Reset:
//    - Drive rst 1 cycle mid-RD_BURST after 2 beats.
//    - All outputs 0 next cycle; state IDLE.
//    - A new read then returns the full line correctly.
//  2 Read, back-to-back beats:
//    - pmem_read, addr 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
//    - burst_address 0x0000_1220.
//    - pmem_resp in cycle 5.
//    - pmem_rdata = {0x44..,0x33..,0x22..,0x11..}.
//  3 Read with stalls:
//    - burst_resp low 3 cycles between beats 1 and 2.
//    - pmem_resp in cycle 8; same line ordering.
//  4 Write:
//    - pmem_write, addr 0x8000_00E0, wdata = {64'hD,64'hC,64'hB,64'hA}.
//    - burst_wdata = A, B, C, D in order; burst_read stays 0.
//    - pmem_resp one cycle after beat D.
//  5 Simultaneous read+write:
//    - Read burst is performed; burst_write never asserts.
//  6 Back-to-back requests:
//    - Read, then write asserted in the cycle after pmem_resp.
//    - Write accepted from IDLE.
//    - pmem_resp pulses exactly once per request.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Responder for the cache pmem line interface: turns one 256-bit line read or write
// into a burst of BEATS memory-side beats and answers with a one-cycle pmem_resp.
module pmem_line_responder #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4,
    parameter int OFF_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pmem_read,
    input  logic                      pmem_write,
    input  logic [31:0]               pmem_address,
    input  logic [BEAT_W*BEATS-1:0]   pmem_wdata,
    output logic [BEAT_W*BEATS-1:0]   pmem_rdata,
    output logic                      pmem_resp,
    output logic                      burst_read,
    output logic                      burst_write,
    output logic [31:0]               burst_address,
    output logic [BEAT_W-1:0]         burst_wdata,
    input  logic [BEAT_W-1:0]         burst_rdata,
    input  logic                      burst_resp
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_beatCnt;
    logic [BEAT_W*BEATS-1:0]   r_lineBuf;
    logic [31:0]               r_burstAddr;
    logic                      r_burstRead;
    logic                      r_burstWrite;
    logic                      r_pmemResp;
    logic                      w_lastBeat;

    assign w_lastBeat = (r_beatCnt == CNT_W'(BEATS - 1));

    // The line buffer serves both directions: read beats land in it, write beats drain from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beatCnt    <= '0;
            r_lineBuf    <= '0;
            r_burstAddr  <= '0;
            r_burstRead  <= 1'b0;
            r_burstWrite <= 1'b0;
            r_pmemResp   <= 1'b0;
        end else begin
            r_pmemResp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pmem_read) begin
                        r_burstAddr <= {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
                        r_beatCnt   <= '0;
                        r_burstRead <= 1'b1;
                        r_state     <= RD_BURST;
                    end else if (pmem_write) begin
                        r_burstAddr  <= {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
                        r_lineBuf    <= pmem_wdata;
                        r_beatCnt    <= '0;
                        r_burstWrite <= 1'b1;
                        r_state      <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        r_lineBuf[r_beatCnt*BEAT_W +: BEAT_W] <= burst_rdata;
                        if (w_lastBeat) begin
                            r_burstRead <= 1'b0;
                            r_pmemResp  <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_beatCnt <= r_beatCnt + 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        if (w_lastBeat) begin
                            r_burstWrite <= 1'b0;
                            r_pmemResp   <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_beatCnt <= r_beatCnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata    = r_lineBuf;
    assign pmem_resp     = r_pmemResp;
    assign burst_read    = r_burstRead;
    assign burst_write   = r_burstWrite;
    assign burst_address = r_burstAddr;
    assign burst_wdata   = r_lineBuf[r_beatCnt*BEAT_W +: BEAT_W];

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: stimulus tasks queue the expected responses,
// and a negedge monitor pops and checks each pmem_resp pulse against them.
module tb_pmem_line_responder;

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int nCompared;
    int nMismatched;
    int cycleCnt;

    typedef struct {
        bit           isRead;
        logic [255:0] line;
        int           issueCycle;
        int           latency;
        string        name;
    } expResp_t;

    expResp_t expQ[$];

    pmem_line_responder dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_address(burst_address),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("burstExclusive", 256'(burst_read & burst_write), 256'd0);
            if (pmem_resp) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResp", 256'd1, 256'd0);
                end else begin
                    expResp_t e;
                    e = expQ.pop_front();
                    checkOutput({e.name, "_latency"}, 256'(cycleCnt - e.issueCycle), 256'(e.latency));
                    if (e.isRead)
                        checkOutput({e.name, "_rdata"}, pmem_rdata, e.line);
                end
            end
        end
    end

    // Issue a read at the current cycle; stalls are inserted before beat 2.
    task automatic applyRead(input string name, input logic [31:0] addr, input logic [255:0] line,
                             input int stallCycles, input bit alsoWrite);
        expResp_t e;
        e.isRead     = 1'b1;
        e.line       = line;
        e.issueCycle = cycleCnt;
        e.latency    = 5 + stallCycles;
        e.name       = name;
        expQ.push_back(e);
        pmem_read    = 1'b1;
        pmem_write   = alsoWrite;
        pmem_address = addr;
        pmem_wdata   = {4{64'hDEAD_BEEF_0BAD_F00D}};
        nextCycle();
        checkOutput({name, "_addr"}, 256'(burst_address), 256'({addr[31:5], 5'b0}));
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                for (int s = 0; s < stallCycles; s++) begin
                    burst_resp  = 1'b0;
                    burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
                    nextCycle();
                end
            end
            checkOutput({name, "_burstRead"}, 256'(burst_read), 256'd1);
            checkOutput({name, "_noBurstWrite"}, 256'(burst_write), 256'd0);
            burst_resp  = 1'b1;
            burst_rdata = line[b*64 +: 64];
            nextCycle();
        end
        burst_resp  = 1'b0;
        burst_rdata = '0;
        checkOutput({name, "_respReadLow"}, 256'(burst_read), 256'd0);
        nextCycle();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    task automatic applyWrite(input string name, input logic [31:0] addr, input logic [255:0] line);
        expResp_t e;
        e.isRead     = 1'b0;
        e.line       = line;
        e.issueCycle = cycleCnt;
        e.latency    = 5;
        e.name       = name;
        expQ.push_back(e);
        pmem_write   = 1'b1;
        pmem_address = addr;
        pmem_wdata   = line;
        nextCycle();
        checkOutput({name, "_addr"}, 256'(burst_address), 256'(addr & 32'hFFFF_FFE0));
        for (int b = 0; b < 4; b++) begin
            checkOutput({name, "_burstWrite"}, 256'(burst_write), 256'd1);
            checkOutput({name, "_noBurstRead"}, 256'(burst_read), 256'd0);
            checkOutput({name, "_wdata"}, 256'(burst_wdata), 256'(line[b*64 +: 64]));
            burst_resp = 1'b1;
            nextCycle();
        end
        burst_resp = 1'b0;
        checkOutput({name, "_respWriteLow"}, 256'(burst_write), 256'd0);
        nextCycle();
        pmem_write = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_rdata"}, pmem_rdata, 256'd0);
        checkOutput({name, "_resp"}, 256'(pmem_resp), 256'd0);
        checkOutput({name, "_bread"}, 256'(burst_read), 256'd0);
        checkOutput({name, "_bwrite"}, 256'(burst_write), 256'd0);
        checkOutput({name, "_baddr"}, 256'(burst_address), 256'd0);
        checkOutput({name, "_bwdata"}, 256'(burst_wdata), 256'd0);
    endtask

    task automatic applyStimulus();
        logic [255:0] lineA;
        logic [255:0] lineB;
        logic [255:0] lineW;
        lineA = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lineB = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
        lineW = {64'hD, 64'hC, 64'hB, 64'hA};

        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        nextCycle();
        nextCycle();
        checkAllZero("reset");
        rst = 1'b0;
        nextCycle();

        applyRead("readB2B", 32'h0000_1234, lineA, 0, 1'b0);
        applyRead("readStall", 32'h0000_2040, lineB, 3, 1'b0);
        applyWrite("write", 32'h8000_00E0, lineW);
        applyRead("readPlusWrite", 32'h0000_3300, lineA, 0, 1'b1);
        applyRead("b2bRead", 32'h0000_4400, lineB, 0, 1'b0);
        applyWrite("b2bWrite", 32'h0000_5500, lineA);

        // Abandon a read after two beats with a one-cycle reset.
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_6666;
        nextCycle();
        for (int b = 0; b < 2; b++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'hCAFE_0000_0000_0000 | 64'(b);
            nextCycle();
        end
        burst_resp = 1'b0;
        rst        = 1'b1;
        pmem_read  = 1'b0;
        nextCycle();
        rst = 1'b0;
        checkAllZero("midBurstReset");
        nextCycle();
        applyRead("readAfterReset", 32'h0000_7777, lineB, 0, 1'b0);

        repeat (4) nextCycle();
        checkOutput("queueDrained", 256'(expQ.size()), 256'd0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
